// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution for the gshare fetch predictor: carries prediction
// metadata F->D->E, redirects fetch on mispredicts, trains the predictor and owns the GHR.
module branch_resolve_unit #(
    parameter int GBIT  = 10,
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid_F,
    input  logic [31:0]      i_pc_F,
    input  logic             i_pred_hit_F,
    input  logic             i_pred_taken_F,
    input  logic [31:0]      i_pred_target_F,
    input  logic             i_stall_D,
    input  logic             i_flush_E,
    input  logic             i_branch_E,
    input  logic             i_jump_E,
    input  logic             i_taken_E,
    input  logic [31:0]      i_target_E,
    output logic [GBIT-1:0]  o_ghr,
    output logic             o_redirect,
    output logic [31:0]      o_redirect_pc,
    output logic             o_flush,
    output logic             o_upd_valid,
    output logic [31:0]      o_upd_pc,
    output logic [GBIT-1:0]  o_upd_idx,
    output logic             o_upd_taken,
    output logic [31:0]      o_upd_target,
    output logic [CNT_W-1:0] o_br_cnt,
    output logic [CNT_W-1:0] o_mispred_cnt
);

    logic            r_d_valid;
    logic [31:0]     r_d_pc;
    logic            r_d_hit;
    logic            r_d_pred_taken;
    logic [31:0]     r_d_pred_target;
    logic [GBIT-1:0] r_d_ckpt;

    logic            r_e_valid;
    logic [31:0]     r_e_pc;
    logic            r_e_hit;
    logic            r_e_pred_taken;
    logic [31:0]     r_e_pred_target;
    logic [GBIT-1:0] r_e_ckpt;

    logic [GBIT-1:0]  r_ghr;
    logic             r_upd_valid;
    logic [31:0]      r_upd_pc;
    logic [GBIT-1:0]  r_upd_idx;
    logic             r_upd_taken;
    logic [31:0]      r_upd_target;
    logic [CNT_W-1:0] r_br_cnt;
    logic [CNT_W-1:0] r_mispred_cnt;

    logic            w_ctl;
    logic            w_act;
    logic [31:0]     w_pc4;
    logic            w_mispred;
    logic            w_redirect;
    logic [31:0]     w_redirect_pc;
    logic [GBIT-1:0] w_ghr_repair;
    logic            w_train;
    logic            w_f_shift;

    assign w_ctl         = i_branch_E | i_jump_E;
    assign w_act         = i_jump_E | i_taken_E;
    assign w_pc4         = r_e_pc + 32'd4;
    assign w_mispred     = (r_e_pred_taken != w_act) | (w_act & (r_e_pred_target != i_target_E));
    // A control op without a BTB hit always redirects; a hit on a non-control op is an alias.
    assign w_redirect    = r_e_valid & ((w_ctl & (~r_e_hit | w_mispred)) | (~w_ctl & r_e_hit));
    assign w_redirect_pc = (w_ctl & w_act) ? i_target_E : w_pc4;
    assign w_ghr_repair  = w_ctl ? {w_act, r_e_ckpt[GBIT-1:1]} : r_e_ckpt;
    assign w_train       = r_e_valid & w_ctl;
    assign w_f_shift     = i_valid_F & i_pred_hit_F & ~i_stall_D & ~w_redirect;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_d_valid       <= 1'b0;
            r_d_pc          <= '0;
            r_d_hit         <= 1'b0;
            r_d_pred_taken  <= 1'b0;
            r_d_pred_target <= '0;
            r_d_ckpt        <= '0;
        end else if (w_redirect) begin
            r_d_valid <= 1'b0;
        end else if (!i_stall_D) begin
            r_d_valid       <= i_valid_F;
            r_d_pc          <= i_pc_F;
            r_d_hit         <= i_pred_hit_F;
            r_d_pred_taken  <= i_pred_taken_F;
            r_d_pred_target <= i_pred_target_F;
            r_d_ckpt        <= r_ghr;
        end
    end

    // E always advances; stall, load-use flush and redirect all turn the slot into a bubble.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_e_valid       <= 1'b0;
            r_e_pc          <= '0;
            r_e_hit         <= 1'b0;
            r_e_pred_taken  <= 1'b0;
            r_e_pred_target <= '0;
            r_e_ckpt        <= '0;
        end else begin
            r_e_valid       <= r_d_valid & ~i_stall_D & ~i_flush_E & ~w_redirect;
            r_e_pc          <= r_d_pc;
            r_e_hit         <= r_d_hit;
            r_e_pred_taken  <= r_d_pred_taken;
            r_e_pred_target <= r_d_pred_target;
            r_e_ckpt        <= r_d_ckpt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ghr <= '0;
        end else if (w_redirect) begin
            r_ghr <= w_ghr_repair;
        end else if (w_f_shift) begin
            r_ghr <= {i_pred_taken_F, r_ghr[GBIT-1:1]};
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_upd_valid   <= 1'b0;
            r_upd_pc      <= '0;
            r_upd_idx     <= '0;
            r_upd_taken   <= 1'b0;
            r_upd_target  <= '0;
            r_br_cnt      <= '0;
            r_mispred_cnt <= '0;
        end else begin
            r_upd_valid <= w_train;
            if (w_train) begin
                r_upd_pc     <= r_e_pc;
                r_upd_idx    <= r_e_pc[GBIT-1:0] ^ r_e_ckpt;
                r_upd_taken  <= w_act;
                r_upd_target <= i_target_E;
                r_br_cnt     <= r_br_cnt + CNT_W'(1);
            end
            if (w_redirect) begin
                r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
            end
        end
    end

    assign o_ghr         = r_ghr;
    assign o_redirect    = w_redirect;
    assign o_redirect_pc = w_redirect_pc;
    assign o_flush       = w_redirect;
    assign o_upd_valid   = r_upd_valid;
    assign o_upd_pc      = r_upd_pc;
    assign o_upd_idx     = r_upd_idx;
    assign o_upd_taken   = r_upd_taken;
    assign o_upd_target  = r_upd_target;
    assign o_br_cnt      = r_br_cnt;
    assign o_mispred_cnt = r_mispred_cnt;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed vectors with literal expectations plus a
// per-cycle comparison against a record-level behavioural model of the F->D->E pipe.
module tb_branch_resolve_unit;

    localparam int GBIT  = 10;
    localparam int CNT_W = 32;

    logic            clk = 1'b0;
    logic            rstN;
    logic            validF, hitF, predTakenF, stallD, flushE, branchE, jumpE, takenE;
    logic [31:0]     pcF, predTargetF, targetE;
    logic [GBIT-1:0] ghr, updIdx;
    logic            redirect, flush, updValid, updTaken;
    logic [31:0]     redirectPc, updPc, updTarget;
    logic [CNT_W-1:0] brCnt, mispredCnt;

    int total = 0;
    int bad   = 0;

    branch_resolve_unit #(.GBIT(GBIT), .CNT_W(CNT_W)) dut (
        .i_clk(clk), .i_rst_n(rstN),
        .i_valid_F(validF), .i_pc_F(pcF), .i_pred_hit_F(hitF),
        .i_pred_taken_F(predTakenF), .i_pred_target_F(predTargetF),
        .i_stall_D(stallD), .i_flush_E(flushE),
        .i_branch_E(branchE), .i_jump_E(jumpE), .i_taken_E(takenE), .i_target_E(targetE),
        .o_ghr(ghr), .o_redirect(redirect), .o_redirect_pc(redirectPc), .o_flush(flush),
        .o_upd_valid(updValid), .o_upd_pc(updPc), .o_upd_idx(updIdx),
        .o_upd_taken(updTaken), .o_upd_target(updTarget),
        .o_br_cnt(brCnt), .o_mispred_cnt(mispredCnt)
    );

    always #5 clk = ~clk;

    // Model: one record per in-flight instruction, history kept as a plain integer.
    typedef struct {
        bit          v;
        logic [31:0] pc;
        bit          hit;
        bit          pt;
        logic [31:0] ptgt;
        int unsigned ck;
    } rec_t;

    rec_t        mD, mE;
    int unsigned mGhr = 0;
    bit          mUpdV = 0, mUpdTaken = 0, mJustReset = 0;
    logic [31:0] mUpdPc = 0, mUpdTgt = 0;
    int unsigned mUpdIdx = 0;
    int unsigned mBr = 0, mMis = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, actual, expected, $time);
        end
    endtask

    // What the E-stage instruction means given the real outcome.
    task automatic resolve(input rec_t e, output bit redir, output logic [31:0] rpc,
                           output int unsigned repair, output bit train, output bit act);
        bit ctl;
        ctl    = branchE || jumpE;
        act    = jumpE || takenE;
        redir  = 0;
        rpc    = e.pc + 32'd4;
        repair = mGhr;
        train  = e.v && ctl;
        if (e.v && ctl) begin
            if (!e.hit || (e.pt != act) || (act && e.ptgt != targetE)) redir = 1;
            if (act) rpc = targetE;
            repair = (e.ck >> 1) + (act ? 512 : 0);
        end else if (e.v && e.hit) begin
            redir  = 1;
            repair = e.ck;
        end
    endtask

    always @(posedge clk) begin
        bit          redir, train, act;
        logic [31:0] rpc;
        int unsigned repair;
        rec_t        nD, nE;
        if (!rstN) begin
            mD.v = 0; mE.v = 0; mGhr = 0; mUpdV = 0; mUpdTaken = 0;
            mUpdPc = 0; mUpdTgt = 0; mUpdIdx = 0; mBr = 0; mMis = 0; mJustReset = 1;
        end else begin
            mJustReset = 0;
            resolve(mE, redir, rpc, repair, train, act);
            mUpdV = train;
            if (train) begin
                mUpdPc    = mE.pc;
                mUpdIdx   = (mE.pc % 1024) ^ mE.ck;
                mUpdTaken = act;
                mUpdTgt   = targetE;
                mBr++;
            end
            if (redir) mMis++;
            nE   = mD;
            nE.v = mD.v && !stallD && !flushE && !redir;
            nD   = mD;
            if (redir) nD.v = 0;
            else if (!stallD) begin
                nD.v = validF; nD.pc = pcF; nD.hit = hitF; nD.pt = predTakenF;
                nD.ptgt = predTargetF; nD.ck = mGhr;
            end
            if (redir) mGhr = repair;
            else if (validF && hitF && !stallD) mGhr = (mGhr >> 1) + (predTakenF ? 512 : 0);
            mD = nD;
            mE = nE;
        end
    end

    // Compare the DUT against the model on every falling edge once out of power-up.
    bit started = 0;
    always @(negedge clk) begin
        bit          redir, train, act;
        logic [31:0] rpc;
        int unsigned repair;
        if (started) begin
            resolve(mE, redir, rpc, repair, train, act);
            if (!rstN) redir = 0;
            checkOutput("redirect", {31'd0, redirect}, {31'd0, redir});
            checkOutput("flush", {31'd0, flush}, {31'd0, redir});
            if (redir) checkOutput("redirect_pc", redirectPc, rpc);
            checkOutput("ghr", {22'd0, ghr}, mGhr);
            checkOutput("upd_valid", {31'd0, updValid}, {31'd0, mUpdV});
            if (mUpdV || mJustReset) begin
                checkOutput("upd_pc", updPc, mUpdPc);
                checkOutput("upd_idx", {22'd0, updIdx}, mUpdIdx);
                checkOutput("upd_taken", {31'd0, updTaken}, {31'd0, mUpdTaken});
                checkOutput("upd_target", updTarget, mUpdTgt);
            end
            checkOutput("br_cnt", brCnt, mBr);
            checkOutput("mispred_cnt", mispredCnt, mMis);
        end
    end

    task automatic nextCycle();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input bit fv, input logic [31:0] fpc, input bit fh, input bit fpt,
                                 input logic [31:0] ftgt, input bit st, input bit fe,
                                 input bit br, input bit jp, input bit tk, input logic [31:0] etgt);
        validF = fv; pcF = fpc; hitF = fh; predTakenF = fpt; predTargetF = ftgt;
        stallD = st; flushE = fe; branchE = br; jumpE = jp; takenE = tk; targetE = etgt;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rstN = 1'b0;
        idle();
        nextCycle();
        started = 1;

        // Reset held low with live traffic on every input.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 32'h100, 1, 1, 32'h200, 0, 0, 1, 0, 0, 32'h300);
            #1;
            checkOutput("rst_ghr", {22'd0, ghr}, 32'h0);
            checkOutput("rst_redirect", {31'd0, redirect}, 32'h0);
            checkOutput("rst_upd_valid", {31'd0, updValid}, 32'h0);
            checkOutput("rst_br_cnt", brCnt, 32'h0);
            checkOutput("rst_mispred_cnt", mispredCnt, 32'h0);
            nextCycle();
        end
        rstN = 1'b1;
        idle();
        nextCycle();

        // Correctly predicted taken branch.
        applyStimulus(1, 32'h100, 1, 1, 32'h200, 0, 0, 0, 0, 0, 0); nextCycle();
        idle(); nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 32'h200);
        #1; checkOutput("t2_redirect", {31'd0, redirect}, 32'h0);
        nextCycle();
        idle();
        #1;
        checkOutput("t2_upd_valid", {31'd0, updValid}, 32'h1);
        checkOutput("t2_upd_idx", {22'd0, updIdx}, 32'h100);
        checkOutput("t2_upd_taken", {31'd0, updTaken}, 32'h1);
        checkOutput("t2_ghr", {22'd0, ghr}, 32'h200);
        checkOutput("t2_br_cnt", brCnt, 32'h1);
        nextCycle();

        // Predicted taken, actually not taken (ckpt 0x200).
        applyStimulus(1, 32'h100, 1, 1, 32'h200, 0, 0, 0, 0, 0, 0); nextCycle();
        idle(); nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h200);
        #1;
        checkOutput("t3_redirect", {31'd0, redirect}, 32'h1);
        checkOutput("t3_redirect_pc", redirectPc, 32'h104);
        checkOutput("t3_flush", {31'd0, flush}, 32'h1);
        nextCycle();
        idle();
        #1;
        checkOutput("t3_ghr", {22'd0, ghr}, 32'h100);
        checkOutput("t3_mispred_cnt", mispredCnt, 32'h1);
        checkOutput("t3_upd_taken", {31'd0, updTaken}, 32'h0);
        nextCycle();

        // JAL without BTB hit (ckpt 0x100).
        applyStimulus(1, 32'h40, 0, 0, 0, 0, 0, 0, 0, 0, 0); nextCycle();
        idle(); nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h80);
        #1;
        checkOutput("t4_redirect", {31'd0, redirect}, 32'h1);
        checkOutput("t4_redirect_pc", redirectPc, 32'h80);
        nextCycle();
        idle();
        #1;
        checkOutput("t4_ghr", {22'd0, ghr}, 32'h280);
        checkOutput("t4_upd_taken", {31'd0, updTaken}, 32'h1);
        checkOutput("t4_upd_target", updTarget, 32'h80);
        checkOutput("t4_upd_idx", {22'd0, updIdx}, 32'h140);
        nextCycle();

        // BTB alias on a non-control instruction (ckpt 0x280).
        applyStimulus(1, 32'h300, 1, 0, 32'h0, 0, 0, 0, 0, 0, 0); nextCycle();
        idle(); nextCycle();
        #1;
        checkOutput("t5_redirect", {31'd0, redirect}, 32'h1);
        checkOutput("t5_redirect_pc", redirectPc, 32'h304);
        nextCycle();
        #1;
        checkOutput("t5_ghr", {22'd0, ghr}, 32'h280);
        checkOutput("t5_upd_valid", {31'd0, updValid}, 32'h0);
        checkOutput("t5_mispred_cnt", mispredCnt, 32'h3);
        nextCycle();

        // Wrapping not-taken mispredict with D stalled behind it.
        applyStimulus(1, 32'hFFFFFFFC, 1, 1, 32'h500, 0, 0, 0, 0, 0, 0); nextCycle();
        applyStimulus(1, 32'h1000, 1, 1, 32'h2000, 0, 0, 0, 0, 0, 0); nextCycle();
        applyStimulus(1, 32'h2000, 1, 1, 32'h3000, 1, 0, 1, 0, 0, 32'h500);
        #1;
        checkOutput("t6_redirect", {31'd0, redirect}, 32'h1);
        checkOutput("t6_redirect_pc", redirectPc, 32'h0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 32'h9999);
        #1;
        checkOutput("t6_ghr", {22'd0, ghr}, 32'h140);
        checkOutput("t6_bubble", {31'd0, redirect}, 32'h0);
        checkOutput("t6_upd_idx", {22'd0, updIdx}, 32'h17C);
        checkOutput("t6_mispred_cnt", mispredCnt, 32'h4);
        checkOutput("t6_br_cnt", brCnt, 32'h4);
        nextCycle();
        #1; checkOutput("t6_d_killed", {31'd0, redirect}, 32'h0);
        nextCycle();
        idle(); nextCycle();

        // Load-use flush turns the E slot into a bubble.
        applyStimulus(1, 32'h500, 1, 1, 32'h600, 0, 0, 0, 0, 0, 0); nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0); nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h600);
        #1; checkOutput("t7_flushE_bubble", {31'd0, redirect}, 32'h0);
        nextCycle();

        // Mixed traffic checked by the model only.
        for (int i = 0; i < 80; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, 32'h1000 + 32'($urandom_range(0, 7)) * 4,
                          $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                          32'h2000 + 32'($urandom_range(0, 1)) * 4,
                          $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0,
                          $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
                          $urandom_range(0, 1) == 1, 32'h2000 + 32'($urandom_range(0, 1)) * 4);
            if (i == 60) rstN = 1'b0;
            if (i == 62) rstN = 1'b1;
            nextCycle();
        end
        idle();
        nextCycle();
        nextCycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
